display_mux_7seg: RTL and testbench
===================================

# display_mux_7seg

Time-multiplexed driver for the four-digit seven-segment display of the irrigation controller. It sits directly downstream of the mm:ss BCD counter chain and of the level/alarm logic. It consumes the four BCD digits and the `Erro`/`Alarme` flags, snapshots them once per scan frame, and drives the shared segment lines `a`–`g`, the colon point, and the digit enables `d1`–`d4`. Segments and digit enables are active-low.

## Interface
Parameters:
- `REFRESH_DIV`, default 50000: clk cycles per digit slot (50 MHz → 1 kHz slot rate, 250 Hz frame rate); legal range ≥ 2.
- `BLINK_FRAMES`, default 125: frames per blink half-period while `alarme` is high (0.5 s at defaults); legal range ≥ 1.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `min_dez` in 4: minutes tens BCD (leftmost digit, `d1`).
- `min_uni` in 4: minutes units BCD (`d2`).
- `seg_dez` in 4: seconds tens BCD (`d3`).
- `seg_uni` in 4: seconds units BCD (`d4`).
- `erro` in 1: level-sensor error flag; overrides the time display.
- `alarme` in 1: alarm flag; blinks the whole display.
- `blank_lz` in 1: blanks `d1` when `min_dez` is 0.
- `a`,`b`,`c`,`d`,`e`,`f`,`g` out 1 each: segment lines, active-low, registered.
- `dp` out 1: colon/decimal point, active-low, lit only in the `d2` slot.
- `d1`,`d2`,`d3`,`d4` out 1 each: digit enables, active-low, registered; at most one low at any time.

## Operation
- **Prescaler.** `div_cnt` counts 0..REFRESH_DIV-1. `tick` is asserted for one cycle when the count equals REFRESH_DIV-1, and the counter then wraps to 0.
- **Slot index.** The 2-bit `slot` advances 0→1→2→3→0 on each `tick`. Slot 0 is `d1` … slot 3 is `d4`. Reset value of `slot` is 3, so the first tick after reset begins a frame.
- **Snapshot.** On the tick that moves `slot` 3→0, the four digits, `erro`, `alarme` and `blank_lz` are latched together. All display content for that frame uses only the latched values, so there is no tearing when the counters carry mid-frame.
- **Blink state.**
  - `blink_on` resets to 1 and `blink_cnt` resets to 0.
  - While the latched `alarme` is 1: `blink_cnt` increments at each frame start. When it reaches BLINK_FRAMES-1 it clears and `blink_on` toggles.
  - While the latched `alarme` is 0: `blink_cnt` is held at 0 and `blink_on` at 1.
- **Glyph selection, in priority order:**
  1. `blink_on`=0: digit enable stays high (dark).
  2. Latched `erro`=1: slots 0/1/2 show "E","r","r"; slot 3 is dark.
  3. Slot 0 with latched `blank_lz`=1 and `min_dez`=0: dark.
  4. Otherwise decode the BCD value. Values 10–15 show "-" (segment g only).
- **Encodings**, listing the segments driven low:
  - 0 = abcdef; 1 = bc; 2 = abdeg; 3 = abcdg; 4 = bcfg; 5 = acdfg; 6 = acdefg; 7 = abc; 8 = abcdefg; 9 = abcdfg.
  - E = adefg; r = eg; "-" = g.
- **`dp`** is 0 only in slot 1, and only when the time is displayed and `blink_on`=1. Otherwise it is 1.

## Timing
- **Reset** (asynchronous, immediate): `a`–`g`=1, `dp`=1, `d1`–`d4`=1, `div_cnt`=0, `slot`=3, snapshot registers=0, `blink_on`=1, `blink_cnt`=0.
- **Ghost blanking.** At the clock edge where `tick` is high:
  - `slot` advances.
  - Segments and `dp` load the new slot's glyph.
  - All four digit enables go high.
  - On the following edge, the new slot's enable goes low, unless that slot is dark.
- **Slot length.** Each digit is therefore enabled for REFRESH_DIV-1 cycles per slot.
- **First-frame latency.** The first lit digit appears REFRESH_DIV+1 cycles after `reset` deasserts.
- **Input sampling latency.** Input changes take effect at the next frame start. Worst case is 4·REFRESH_DIV cycles.
- **Reset mid-frame.** Outputs go dark immediately, and the sequence restarts exactly as after power-up.
- **Simultaneous `erro` and `alarme`.** "Err" is shown and blinks.

## Test plan
- **Reset and first frame.** REFRESH_DIV=4; assert `reset` mid-scan.
  - All outputs are 1 immediately.
  - After release, `d1` goes low at cycle 5.
  - Then `d2`/`d3`/`d4` go low in turn every 4 cycles, with a 1-cycle all-high gap before each.
- **Digit decode.** Inputs 1,2,5,9.
  - `d1` slot shows segments bc = 0 and the rest 1; `d2` slot shows abdeg = 0 with `dp`=0; `d3` slot shows acdfg = 0; `d4` slot shows abcdfg = 0.
  - Sweep 0–15 on `seg_uni`: 10–15 give g-only.
- **Snapshot coherence.** Change all digits from 0,9,5,9 to 1,0,0,0 during slot 2.
  - The rest of that frame still shows 5,9 in `d3`/`d4`.
  - The next frame shows 1,0,0,0.
- **Error override.** `erro`=1, digits 3,4,5,6.
  - Slots show E (adefg), r (eg), r (eg).
  - `d4` stays high the whole slot; `dp`=1.
- **Alarm blink.** BLINK_FRAMES=2, `alarme`=1.
  - Digit enables alternate: 2 frames lit, 2 frames fully dark.
  - Dropping `alarme` restores the lit display at the next frame start.
- **Leading-zero blank.** `blank_lz`=1, `min_dez`=0: `d1` never goes low. With `min_dez`=1: `d1` lit showing bc.

Source files
------------

// File: rtl/display_mux_7seg.sv
// Four-digit multiplexed seven-segment driver with per-frame input snapshot,
// error override, alarm blink and leading-zero blanking. Outputs are active-low.
module display_mux_7seg #(
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLINK_FRAMES = 125
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] min_dez,
    input  logic [3:0] min_uni,
    input  logic [3:0] seg_dez,
    input  logic [3:0] seg_uni,
    input  logic       erro,
    input  logic       alarme,
    input  logic       blank_lz,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g,
    output logic       dp,
    output logic       d1,
    output logic       d2,
    output logic       d3,
    output logic       d4
);

    localparam int unsigned DivW   = $clog2(REFRESH_DIV);
    localparam int unsigned BlinkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DivW-1:0]   DivMax   = DivW'(REFRESH_DIV - 1);
    localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_FRAMES - 1);

    // Lit-segment masks, bit order {a,b,c,d,e,f,g}
    localparam logic [6:0] MaskE    = 7'b1001111;
    localparam logic [6:0] MaskR    = 7'b0000101;
    localparam logic [6:0] MaskDash = 7'b0000001;

    function automatic logic [6:0] bcd_mask(input logic [3:0] v);
        logic [6:0] m;
        case (v)
            4'd0:    m = 7'b1111110;
            4'd1:    m = 7'b0110000;
            4'd2:    m = 7'b1101101;
            4'd3:    m = 7'b1111001;
            4'd4:    m = 7'b0110011;
            4'd5:    m = 7'b1011011;
            4'd6:    m = 7'b1011111;
            4'd7:    m = 7'b1110000;
            4'd8:    m = 7'b1111111;
            4'd9:    m = 7'b1111011;
            default: m = MaskDash;
        endcase
        return m;
    endfunction

    logic [DivW-1:0]   div_cnt_q, div_cnt_d;
    logic [1:0]        slot_q, slot_d;
    logic [15:0]       digits_q, digits_d;
    logic              erro_q, erro_d;
    logic              alarme_q, alarme_d;
    logic              blank_q, blank_d;
    logic              blink_on_q, blink_on_d;
    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic [3:0]        en_q, en_d;
    logic              pend_q, pend_d;
    logic              dark_q, dark_d;

    logic       tick;
    logic       frame_start;
    logic       dark;
    logic [3:0] cur_digit;
    logic [6:0] mask;

    always_comb begin
        tick        = (div_cnt_q == DivMax);
        frame_start = tick && (slot_q == 2'd3);
        div_cnt_d   = tick ? '0 : div_cnt_q + 1'b1;
        slot_d      = tick ? slot_q + 2'd1 : slot_q;

        digits_d    = digits_q;
        erro_d      = erro_q;
        alarme_d    = alarme_q;
        blank_d     = blank_q;
        blink_on_d  = blink_on_q;
        blink_cnt_d = blink_cnt_q;
        if (frame_start) begin
            digits_d = {min_dez, min_uni, seg_dez, seg_uni};
            erro_d   = erro;
            alarme_d = alarme;
            blank_d  = blank_lz;
            if (alarme) begin
                if (blink_cnt_q == BlinkMax) begin
                    blink_cnt_d = '0;
                    blink_on_d  = ~blink_on_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + 1'b1;
                end
            end else begin
                blink_cnt_d = '0;
                blink_on_d  = 1'b1;
            end
        end

        // Glyph is built from next-state values so a frame's first slot already
        // reflects the snapshot taken on the same edge.
        case (slot_d)
            2'd0:    cur_digit = digits_d[15:12];
            2'd1:    cur_digit = digits_d[11:8];
            2'd2:    cur_digit = digits_d[7:4];
            default: cur_digit = digits_d[3:0];
        endcase

        dark = !blink_on_d
            || (erro_d && slot_d == 2'd3)
            || (!erro_d && slot_d == 2'd0 && blank_d && digits_d[15:12] == 4'd0);

        if (erro_d) begin
            mask = (slot_d == 2'd0) ? MaskE : MaskR;
        end else begin
            mask = bcd_mask(cur_digit);
        end

        seg_d  = seg_q;
        dp_d   = dp_q;
        en_d   = en_q;
        pend_d = 1'b0;
        dark_d = dark_q;
        if (tick) begin
            seg_d  = dark ? 7'h7F : ~mask;
            dp_d   = ~(slot_d == 2'd1 && !erro_d && blink_on_d);
            en_d   = 4'hF;
            pend_d = 1'b1;
            dark_d = dark;
        end else if (pend_q && !dark_q) begin
            // One all-off cycle after each slot change suppresses ghosting
            en_d = ~(4'b1000 >> slot_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q   <= '0;
            slot_q      <= 2'd3;
            digits_q    <= '0;
            erro_q      <= 1'b0;
            alarme_q    <= 1'b0;
            blank_q     <= 1'b0;
            blink_on_q  <= 1'b1;
            blink_cnt_q <= '0;
            seg_q       <= 7'h7F;
            dp_q        <= 1'b1;
            en_q        <= 4'hF;
            pend_q      <= 1'b0;
            dark_q      <= 1'b1;
        end else begin
            div_cnt_q   <= div_cnt_d;
            slot_q      <= slot_d;
            digits_q    <= digits_d;
            erro_q      <= erro_d;
            alarme_q    <= alarme_d;
            blank_q     <= blank_d;
            blink_on_q  <= blink_on_d;
            blink_cnt_q <= blink_cnt_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            en_q        <= en_d;
            pend_q      <= pend_d;
            dark_q      <= dark_d;
        end
    end

    assign {a, b, c, d, e, f, g} = seg_q;
    assign dp                    = dp_q;
    assign {d1, d2, d3, d4}      = en_q;

endmodule

// File: tb/tb_display_mux_7seg.sv
// Scoreboard bench for display_mux_7seg: expected lit slots are queued by the
// stimulus process and consumed by a monitor whenever a digit enable goes low.
module tb_display_mux_7seg;

    localparam int unsigned RDiv = 4;
    localparam int unsigned BFrm = 2;

    // Active-low {a..g} codes
    localparam logic [6:0] CodeE    = 7'b0110000;
    localparam logic [6:0] CodeR    = 7'b1111010;
    localparam logic [6:0] CodeDash = 7'b1111110;

    typedef struct packed {
        logic [3:0] dig;
        logic [6:0] seg;
        logic       pt;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] min_dez = '0, min_uni = '0, seg_dez = '0, seg_uni = '0;
    logic       erro = 1'b0, alarme = 1'b0, blank_lz = 1'b0;
    logic       a, b, c, d, e, f, g, dp, d1, d2, d3, d4;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  low_cnt[4] = '{0, 0, 0, 0};
    int  cur_edge = 0;

    display_mux_7seg #(
        .REFRESH_DIV (RDiv),
        .BLINK_FRAMES(BFrm)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .min_dez (min_dez),
        .min_uni (min_uni),
        .seg_dez (seg_dez),
        .seg_uni (seg_uni),
        .erro    (erro),
        .alarme  (alarme),
        .blank_lz(blank_lz),
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d),
        .e       (e),
        .f       (f),
        .g       (g),
        .dp      (dp),
        .d1      (d1),
        .d2      (d2),
        .d3      (d3),
        .d4      (d4)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_code(input int v);
        case (v)
            0:       return 7'b0000001;
            1:       return 7'b1001111;
            2:       return 7'b0010010;
            3:       return 7'b0000110;
            4:       return 7'b1001100;
            5:       return 7'b0100100;
            6:       return 7'b0100000;
            7:       return 7'b0001111;
            8:       return 7'b0000000;
            9:       return 7'b0000100;
            default: return CodeDash;
        endcase
    endfunction

    task automatic push_slot(input int s, input logic [6:0] sg, input logic pt);
        ev_t ev;
        ev.dig = 4'b1111;
        ev.dig[3-s] = 1'b0;
        ev.seg = sg;
        ev.pt  = pt;
        exp_q.push_back(ev);
    endtask

    task automatic push_time(input int v0, input int v1, input int v2, input int v3);
        push_slot(0, seg_code(v0), 1'b1);
        push_slot(1, seg_code(v1), 1'b0);
        push_slot(2, seg_code(v2), 1'b1);
        push_slot(3, seg_code(v3), 1'b1);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic set_digits(input int v0, input int v1, input int v2, input int v3);
        min_dez = 4'(v0);
        min_uni = 4'(v1);
        seg_dez = 4'(v2);
        seg_uni = 4'(v3);
    endtask

    task automatic hold_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        reset = 1'b0;
        cur_edge = 0;
    endtask

    task automatic adv(input int n);
        repeat (n - cur_edge) @(posedge clk);
        #1;
        cur_edge = n;
    endtask

    // Monitor: one comparison per newly lit slot, plus a per-cycle one-hot check
    initial begin : monitor
        logic [3:0] prev;
        logic [3:0] cur;
        ev_t        got;
        ev_t        exp_ev;
        prev = 4'hF;
        forever begin
            @(negedge clk);
            cur = {d1, d2, d3, d4};
            for (int s = 0; s < 4; s++) begin
                if (cur[3-s] == 1'b0) low_cnt[s]++;
            end
            checks++;
            if ($countones(~cur) > 1) begin
                errors++;
                $display("FAIL onehot_enable: got %b, expected at most one low", cur);
            end
            if (!reset && cur != 4'hF && prev == 4'hF) begin
                got = '{dig: cur, seg: {a, b, c, d, e, f, g}, pt: dp};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_slot: got dig=%b seg=%b dp=%b, expected no lit slot",
                             got.dig, got.seg, got.pt);
                end else begin
                    exp_ev = exp_q.pop_front();
                    if (got !== exp_ev) begin
                        errors++;
                        $display("FAIL slot_glyph: got dig=%b seg=%b dp=%b, expected dig=%b seg=%b dp=%b",
                                 got.dig, got.seg, got.pt, exp_ev.dig, exp_ev.seg, exp_ev.pt);
                    end
                end
            end
            prev = reset ? 4'hF : cur;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int base;
        logic [3:0] exp_dig;

        // Reset and first frame: run into slot d3, then reset mid-scan
        hold_reset();
        set_digits(1, 2, 5, 9);
        push_slot(0, seg_code(1), 1'b1);
        push_slot(1, seg_code(2), 1'b0);
        push_slot(2, seg_code(5), 1'b1);
        release_reset();
        adv(14);
        #2 reset = 1'b1;
        #1;
        chk("reset_enables", int'({d1, d2, d3, d4}), 15);
        chk("reset_segments", int'({a, b, c, d, e, f, g}), 127);
        chk("reset_dp", int'(dp), 1);
        repeat (2) @(posedge clk);
        #1;
        push_time(1, 2, 5, 9);
        push_time(1, 2, 5, 9);
        release_reset();
        for (int k = 1; k <= 36; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp_dig = 4'hF;
            if (k >= 5 && ((k - 4) % 4) != 0) exp_dig[3 - (((k - 4) / 4) % 4)] = 1'b0;
            chk($sformatf("scan_timing_cycle%0d", k), int'({d1, d2, d3, d4}), int'(exp_dig));
        end
        cur_edge = 36;
        chk("drain_first_frames", exp_q.size(), 0);

        // Sweep 0..15 on seg_uni, one value per frame
        hold_reset();
        set_digits(8, 8, 8, 0);
        for (int fr = 0; fr < 16; fr++) push_time(8, 8, 8, fr);
        release_reset();
        for (int fr = 0; fr < 16; fr++) begin
            adv(4 + 16 * fr);
            seg_uni = 4'(fr + 1);
        end
        adv(4 + 16 * 16);
        chk("drain_sweep", exp_q.size(), 0);

        // Snapshot coherence: inputs change while d3 is lit
        hold_reset();
        set_digits(0, 9, 5, 9);
        push_time(0, 9, 5, 9);
        push_time(1, 0, 0, 0);
        release_reset();
        adv(13);
        set_digits(1, 0, 0, 0);
        adv(36);
        chk("drain_snapshot", exp_q.size(), 0);

        // Error override
        hold_reset();
        set_digits(3, 4, 5, 6);
        erro = 1'b1;
        for (int fr = 0; fr < 2; fr++) begin
            push_slot(0, CodeE, 1'b1);
            push_slot(1, CodeR, 1'b1);
            push_slot(2, CodeR, 1'b1);
        end
        release_reset();
        adv(4);
        base = low_cnt[3];
        adv(36);
        chk("error_d4_dark", low_cnt[3] - base, 0);
        chk("drain_error", exp_q.size(), 0);
        erro = 1'b0;

        // Alarm blink: frames lit, dark, dark, lit, lit, dark; drop alarm -> lit
        hold_reset();
        set_digits(1, 2, 3, 4);
        alarme = 1'b1;
        push_time(1, 2, 3, 4);
        push_time(1, 2, 3, 4);
        push_time(1, 2, 3, 4);
        push_time(1, 2, 3, 4);
        release_reset();
        adv(20);
        base = low_cnt[0] + low_cnt[1] + low_cnt[2] + low_cnt[3];
        adv(52);
        chk("blink_dark_frames", low_cnt[0] + low_cnt[1] + low_cnt[2] + low_cnt[3] - base, 0);
        adv(84);
        alarme = 1'b0;
        adv(116);
        chk("drain_blink", exp_q.size(), 0);

        // Leading-zero blanking, then min_dez=1 shows in d1
        hold_reset();
        set_digits(0, 1, 2, 3);
        blank_lz = 1'b1;
        push_slot(1, seg_code(1), 1'b0);
        push_slot(2, seg_code(2), 1'b1);
        push_slot(3, seg_code(3), 1'b1);
        push_time(1, 1, 2, 3);
        release_reset();
        adv(4);
        base = low_cnt[0];
        min_dez = 4'd1;
        adv(20);
        chk("lz_d1_dark", low_cnt[0] - base, 0);
        adv(36);
        chk("lz_d1_lit_cycles", low_cnt[0] - base, int'(RDiv - 1));
        chk("drain_lz", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
